// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// default PC parameters and the bubble/flush instruction word.
package if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'h0000_0004;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;

endpackage : if_pkg

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register. Flush beats everything, then a load of a new
// instruction, then stall (hold); with none of these the entry becomes a bubble.
module if_id_reg
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    // IF/ID register update: flush, load, hold or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0000_0000;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0000_0000;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end else if (stall_i) begin
            valid_q <= valid_q;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule : if_id_reg

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, runs a single-outstanding req/gnt/rvalid fetch and
// feeds the IF/ID register. Optional macro DELAY_SLOT_EN turns redirects into
// delayed branches (no flush; the latched target replaces the next PC step).
module inst_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        req_q;
    logic [31:0] next_seq_pc_s;
    logic        pc_adv_s;
    logic        load_s;
    logic        flush_s;
    logic [31:0] load_inst_s;
    logic [31:0] load_pc_s;
`ifdef DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] target_q, target_d;

    // Next "sequential" PC: a fresh or latched redirect target wins over the step
    always_comb begin
        if (redirect_valid) begin
            next_seq_pc_s = redirect_pc;
        end else if (pend_q) begin
            next_seq_pc_s = target_q;
        end else begin
            next_seq_pc_s = pc_q + PC_STEP;
        end
    end
`else
    // Next sequential PC wraps naturally at 32 bits
    always_comb begin
        next_seq_pc_s = pc_q + PC_STEP;
    end
`endif

    // Next-state, PC, hold buffer and IF/ID control
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        pc_adv_s    = 1'b0;
        load_s      = 1'b0;
        flush_s     = 1'b0;
        load_inst_s = imem_rdata;
        load_pc_s   = pc_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
                else          state_d = S_REQ;
            end
            S_WAIT: begin
                if (!imem_rvalid) begin
                    state_d = S_WAIT;
                end else if (kill_q) begin
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end else if (!id_stall) begin
                    load_s   = 1'b1;
                    pc_adv_s = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    hold_inst_d = imem_rdata;
                    hold_pc_d   = pc_q;
                    pc_adv_s    = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    load_s      = 1'b1;
                    load_inst_s = hold_inst_q;
                    load_pc_s   = hold_pc_q;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pc_adv_s) begin
            pc_d = next_seq_pc_s;
        end else begin
            pc_d = pc_q;
        end
`ifndef DELAY_SLOT_EN
        // Flushing redirect overrides stall and rvalid in the same cycle
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            flush_s     = 1'b1;
            load_s      = 1'b0;
            hold_inst_d = NOP_INST;
            hold_pc_d   = 32'h0000_0000;
            case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_HOLD:  state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
        end else begin
            flush_s = 1'b0;
        end
`endif
    end

`ifdef DELAY_SLOT_EN
    // Pending target: consumed by the next PC update, overwritten by a newer redirect
    always_comb begin
        pend_d   = pend_q;
        target_d = target_q;
        if (pc_adv_s) begin
            pend_d = 1'b0;
        end else if (redirect_valid) begin
            pend_d   = 1'b1;
            target_d = redirect_pc;
        end else begin
            pend_d = pend_q;
        end
    end

    // Redirect-pending registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q   <= 1'b0;
            target_q <= 32'h0000_0000;
        end else begin
            pend_q   <= pend_d;
            target_q <= target_d;
        end
    end
`endif

    // Fetch FSM, PC, kill flag, hold buffer and registered request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            hold_inst_q <= NOP_INST;
            hold_pc_q   <= 32'h0000_0000;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            req_q       <= (state_d == S_REQ);
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (load_s),
        .flush_i (flush_s),
        .stall_i (id_stall),
        .inst_i  (load_inst_s),
        .pc_i    (load_pc_s),
        .valid_o (id_valid),
        .inst_o  (id_inst),
        .pc_o    (id_pc)
    );

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Directed, table-driven bench for inst_fetch (default build, flushing redirects).
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    task automatic add(input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic re, input logic [31:0] rp,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.stall = st; v.redir = re; v.rpc = rp;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, ".imem_req"},  {31'd0, imem_req}, {31'd0, er});
        chk({tag, ".imem_addr"}, imem_addr, ea);
        chk({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, ev});
        chk({tag, ".id_inst"},   id_inst, ei);
        chk({tag, ".id_pc"},     id_pc, ep);
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic st, input logic re, input logic [31:0] rp);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        id_stall = st; redirect_valid = re; redirect_pc = rp;
    endtask

    initial begin
        //  gnt rv  rdata          st  re  rpc            req addr          val inst           idpc
        // sequential fetch with 1-cycle memory
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 32'hAAAA0000,  0, 0, 32'h0,         1, 32'h4,         1, 32'hAAAA0000,  32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         0, 32'hAAAA0000,  32'h0);
        add(0, 1, 32'hBBBB0004,  0, 0, 32'h0,         1, 32'h8,         1, 32'hBBBB0004,  32'h4);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h8,         0, 32'hBBBB0004,  32'h4);
        add(0, 1, 32'hCCCC0008,  0, 0, 32'h0,         1, 32'hC,         1, 32'hCCCC0008,  32'h8);
        // gnt held low: request and address stable
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC,         0, 32'hCCCC0008,  32'h8);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC,         0, 32'hCCCC0008,  32'h8);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC,         0, 32'hCCCC0008,  32'h8);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'hC,         0, 32'hCCCC0008,  32'h8);
        // stalled response goes to hold buffer, released when stall drops
        add(0, 1, 32'h24020005,  1, 0, 32'h0,         0, 32'h10,        0, 32'hCCCC0008,  32'h8);
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h10,        0, 32'hCCCC0008,  32'h8);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h10,        1, 32'h24020005,  32'hC);
        // redirect while waiting without rvalid: response killed
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h10,        0, 32'h24020005,  32'hC);
        add(0, 0, 32'h0,         0, 1, 32'h100,       0, 32'h100,       0, 32'h0,         32'h0);
        add(0, 1, 32'hDEAD0010,  0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h0);
        add(0, 1, 32'h11110100,  0, 0, 32'h0,         1, 32'h104,       1, 32'h11110100,  32'h100);
        // redirect with stall while IF/ID valid: flush beats stall
        add(0, 0, 32'h0,         1, 1, 32'h200,       1, 32'h200,       0, 32'h0,         32'h0);
        // redirect in REQ with gnt in same cycle: WAIT with kill
        add(1, 0, 32'h0,         0, 1, 32'h300,       0, 32'h300,       0, 32'h0,         32'h0);
        add(0, 1, 32'h55555555,  0, 0, 32'h0,         1, 32'h300,       0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h300,       0, 32'h0,         32'h0);
        add(0, 1, 32'h66660300,  0, 0, 32'h0,         1, 32'h304,       1, 32'h66660300,  32'h300);
        // redirect in WAIT together with rvalid and stall: data dropped
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h304,       0, 32'h66660300,  32'h300);
        add(0, 1, 32'h77777777,  1, 1, 32'h400,       1, 32'h400,       0, 32'h0,         32'h0);
        // redirect in HOLD clears the hold buffer
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h400,       0, 32'h0,         32'h0);
        add(0, 1, 32'h88880400,  1, 0, 32'h0,         0, 32'h404,       0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 1, 32'h500,       1, 32'h500,       0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h500,       0, 32'h0,         32'h0);
        add(0, 1, 32'h99990500,  0, 0, 32'h0,         1, 32'h504,       1, 32'h99990500,  32'h500);
        // 32-bit PC wrap
        add(0, 0, 32'h0,         0, 1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC,  0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'hFFFFFFFC,  0, 32'h0,         32'h0);
        add(0, 1, 32'hABCDEF01,  0, 0, 32'h0,         1, 32'h0,         1, 32'hABCDEF01,  32'hFFFFFFFC);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'hABCDEF01,  32'hFFFFFFFC);

        // reset state
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("post_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // table vectors: drive on negedge, check after the following posedge
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc);
        end

        // reset mid-WAIT with rvalid arriving during and after reset
        @(negedge clk);
        drive(0, 1, 32'hBAD0BAD0, 0, 0, 32'h0);
        rst = 1'b0;
        #1;
        chk_all("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("rst_release", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("rst_first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(0, 1, 32'hBAD1BAD1, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("rst_rvalid_in_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // redirect during IDLE: pc updated, no kill
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 1, 32'h80);
        @(posedge clk);
        #1;
        chk_all("idle_redir", 1'b1, 32'h80, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, 32'h12340080, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("idle_redir_fetch", 1'b1, 32'h84, 1'b1, 32'h12340080, 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inst_fetch
